// File: rtl/registro_desplazable_param.sv
// Parametrised universal shift register with single-step shift/rotate/load/ashift
// and a multi-cycle burst mode with BUSY/DONE handshake.
module registro_desplazable_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [2:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [AMT_W-1:0] AMT,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [1:0] K_SHIFT = 2'd0;
    localparam logic [1:0] K_ROT   = 2'd1;
    localparam logic [1:0] K_ASH   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             rot_q, rot_d;
    logic             dir_q, dir_d;
    logic [WIDTH:0]   stp;

    // Returns {departing bit, next register value} for one step.
    function automatic logic [WIDTH:0] step_f(input logic [1:0] kind, input logic dir,
                                              input logic [WIDTH-1:0] q, input logic sin);
        logic fill;
        logic out;
        out = dir ? q[0] : q[WIDTH-1];
        case (kind)
            K_ROT:   fill = out;
            K_ASH:   fill = dir ? q[WIDTH-1] : 1'b0;
            default: fill = sin;
        endcase
        if (dir) return {out, fill, q[WIDTH-1:1]};
        else     return {out, q[WIDTH-2:0], fill};
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        dir_d   = dir_q;
        stp     = '0;
        case (state_q)
            IDLE: begin
                if (ENB) begin
                    case (MODO)
                        3'b000, 3'b001, 3'b100: begin
                            stp    = step_f((MODO == 3'b000) ? K_SHIFT :
                                            (MODO == 3'b001) ? K_ROT : K_ASH,
                                            DIR, q_q, S_IN);
                            q_d    = stp[WIDTH-1:0];
                            sout_d = stp[WIDTH];
                        end
                        3'b010: q_d = D;
                        3'b101, 3'b110: begin
                            if (START) begin
                                rot_d   = (MODO == 3'b110);
                                dir_d   = DIR;
                                cnt_d   = AMT;
                                state_d = (AMT != '0) ? RUN : FIN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (ENB) begin
                    stp    = step_f(rot_q ? K_ROT : K_SHIFT, dir_q, q_q, S_IN);
                    q_d    = stp[WIDTH-1:0];
                    sout_d = stp[WIDTH];
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            rot_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
            dir_q   <= dir_d;
        end
    end

    assign Q     = q_q;
    assign S_OUT = sout_q;
    assign BUSY  = (state_q == RUN);
    assign DONE  = (state_q == FIN);

endmodule

// File: tb/tb_registro_desplazable_param.sv
// Directed bench for registro_desplazable_param (WIDTH=8, AMT_W=4).
module tb_registro_desplazable_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       ENB;
    logic       DIR;
    logic       S_IN;
    logic [2:0] MODO;
    logic [7:0] D;
    logic [3:0] AMT;
    logic       START;
    logic [7:0] Q;
    logic       S_OUT;
    logic       BUSY;
    logic       DONE;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    registro_desplazable_param #(.WIDTH(8), .AMT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .ENB   (ENB),
        .DIR   (DIR),
        .S_IN  (S_IN),
        .MODO  (MODO),
        .D     (D),
        .AMT   (AMT),
        .START (START),
        .Q     (Q),
        .S_OUT (S_OUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                           input logic eb, input logic ed);
        chk({tag, ".Q"}, 32'(Q), 32'(eq));
        chk({tag, ".S_OUT"}, 32'(S_OUT), 32'(es));
        chk({tag, ".BUSY"}, 32'(BUSY), 32'(eb));
        chk({tag, ".DONE"}, 32'(DONE), 32'(ed));
    endtask

    initial begin
        rst = 1'b1; ENB = 1'b0; DIR = 1'b0; S_IN = 1'b0;
        MODO = 3'b011; D = 8'h00; AMT = 4'd0; START = 1'b0;
        tick(1);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        rst = 1'b0; ENB = 1'b1; MODO = 3'b010; D = 8'hA5;
        tick(1);
        chk_all("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Idle with ENB=0 ignores START
        ENB = 1'b0; MODO = 3'b110; AMT = 4'd3; START = 1'b1;
        tick(1);
        chk_all("enb0_hold", 8'hA5, 1'b0, 1'b0, 1'b0);
        START = 1'b0; ENB = 1'b1;

        MODO = 3'b111; tick(1);
        chk("reserved_hold.Q", 32'(Q), 32'h0000_00A5);

        MODO = 3'b010; D = 8'h00; tick(1);
        MODO = 3'b000; DIR = 1'b0; S_IN = 1'b1;
        tick(4);
        chk_all("shl4", 8'h0F, 1'b0, 1'b0, 1'b0);

        MODO = 3'b010; D = 8'h81; tick(1);
        MODO = 3'b001; DIR = 1'b0; tick(1);
        chk_all("rotl", 8'h03, 1'b1, 1'b0, 1'b0);

        MODO = 3'b010; D = 8'h90; tick(1);
        MODO = 3'b100; DIR = 1'b1; tick(2);
        chk_all("asr2", 8'hE4, 1'b0, 1'b0, 1'b0);
        DIR = 1'b0; tick(1);
        chk_all("asl1", 8'hC8, 1'b1, 1'b0, 1'b0);

        MODO = 3'b010; D = 8'h01; tick(1);
        MODO = 3'b110; DIR = 1'b1; AMT = 4'd3; START = 1'b1;
        tick(1);
        chk_all("brot_latch", 8'h01, 1'b1, 1'b1, 1'b0);
        START = 1'b0; MODO = 3'b010; D = 8'hFF; DIR = 1'b0; AMT = 4'd0;
        tick(1);
        chk_all("brot_s1", 8'h80, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_all("brot_s2", 8'h40, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_all("brot_done", 8'h20, 1'b0, 1'b0, 1'b1);
        MODO = 3'b011;
        tick(1);
        chk_all("brot_idle", 8'h20, 1'b0, 1'b0, 1'b0);

        MODO = 3'b010; D = 8'h01; tick(1);
        MODO = 3'b110; DIR = 1'b1; AMT = 4'd3; START = 1'b1;
        tick(1);
        START = 1'b0; MODO = 3'b011;
        tick(1);
        chk_all("pause_s1", 8'h80, 1'b1, 1'b1, 1'b0);
        ENB = 1'b0;
        tick(2);
        chk_all("pause_frozen", 8'h80, 1'b1, 1'b1, 1'b0);
        ENB = 1'b1;
        tick(1);
        chk_all("pause_s2", 8'h40, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_all("pause_done", 8'h20, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk("pause_after.DONE", 32'(DONE), 32'd0);

        MODO = 3'b110; AMT = 4'd0; START = 1'b1;
        tick(1);
        chk_all("amt0_done", 8'h20, 1'b0, 1'b0, 1'b1);
        START = 1'b0; MODO = 3'b011;
        tick(1);
        chk_all("amt0_idle", 8'h20, 1'b0, 1'b0, 1'b0);

        MODO = 3'b010; D = 8'h00; tick(1);
        MODO = 3'b101; DIR = 1'b0; AMT = 4'd10; START = 1'b1; S_IN = 1'b1;
        tick(1);
        START = 1'b0; MODO = 3'b011;
        tick(4);
        chk_all("bshl_4", 8'h0F, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick(1);
        chk_all("bshl_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1);
        chk_all("bshl_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        MODO = 3'b101; START = 1'b1;
        tick(1);
        START = 1'b0; MODO = 3'b011;
        tick(9);
        chk_all("bshl_9", 8'hFF, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_all("bshl_done", 8'hFF, 1'b1, 1'b0, 1'b1);
        tick(1);
        chk_all("bshl_idle", 8'hFF, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
